// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, owner encoding and error-flag bit positions.
package dmem_arb_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DBG  = 1'b1
    } arb_owner_e;

    localparam int unsigned ERR_W    = 2;
    localparam int unsigned ERR_TMO  = 0;  // read response synthesised after timeout
    localparam int unsigned ERR_SPUR = 1;  // memory rvalid with no read outstanding

endpackage

// File: rtl/arb_prio_sel.sv
// Grant selection between core and debug requesters with a starvation counter.
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_core_req, i_dbg_req   live requests from each requester
//   i_core_gnt, i_dbg_gnt   grant actually issued this cycle
//   o_sel_c                 combinational owner choice for the current cycle
module arb_prio_sel
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_core_req,
    input  logic       i_dbg_req,
    input  logic       i_core_gnt,
    input  logic       i_dbg_gnt,
    output arb_owner_e o_sel_c
);

    localparam int unsigned CNT_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_forced;

    assign w_forced = (r_starve_cnt == CNT_W'(STARVE_LIM));

    // Core wins unless debug is alone or has been passed over STARVE_LIM times.
    always_comb begin
        o_sel_c = OWN_CORE;
        if (i_dbg_req && (!i_core_req || w_forced)) begin
            o_sel_c = OWN_DBG;
        end
    end

    // Counts core grants taken while debug waits; saturates so debug stays forced.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_starve_cnt <= '0;
        end else if (i_dbg_gnt || !i_dbg_req) begin
            r_starve_cnt <= '0;
        end else if (i_core_gnt && !w_forced) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core LSU and a debug/DMA requester.
// One transaction in flight; loads park the FSM in RD_WAIT until rvalid or timeout.
// Ports:
//   i_clk, i_rst_n                          clock, synchronous active-low reset
//   i_core_* / o_core_gnt,rvalid,rdata      core LSU request/response, o_core_stall freezes core
//   i_dbg_*  / o_dbg_gnt,rvalid,rdata       debug/DMA request/response
//   o_mem_* / i_mem_ready,rvalid,rdata      shared memory port
//   o_err                                   sticky [0] timeout, [1] spurious rvalid
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_LIM = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_core_req,
    input  logic                i_core_we,
    input  logic [ADDR_W-1:0]   i_core_addr,
    input  logic [DATA_W-1:0]   i_core_wdata,
    input  logic [DATA_W/8-1:0] i_core_bmask,
    output logic                o_core_gnt,
    output logic                o_core_rvalid,
    output logic [DATA_W-1:0]   o_core_rdata,
    output logic                o_core_stall,
    input  logic                i_dbg_req,
    input  logic                i_dbg_we,
    input  logic [ADDR_W-1:0]   i_dbg_addr,
    input  logic [DATA_W-1:0]   i_dbg_wdata,
    input  logic [DATA_W/8-1:0] i_dbg_bmask,
    output logic                o_dbg_gnt,
    output logic                o_dbg_rvalid,
    output logic [DATA_W-1:0]   o_dbg_rdata,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_bmask,
    input  logic                i_mem_ready,
    input  logic                i_mem_rvalid,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic [ERR_W-1:0]    o_err
);

    localparam int unsigned TMO_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    arb_owner_e          r_owner;
    arb_owner_e          w_owner_nxt;
    arb_owner_e          w_sel;
    logic [TMO_W-1:0]    r_tmo_cnt;
    logic [ERR_W-1:0]    r_err;
    logic                w_any_req;
    logic                w_sel_we;
    logic                w_core_gnt;
    logic                w_dbg_gnt;
    logic                w_rsp_valid;
    logic                w_tmo_fire;
    logic [DATA_W-1:0]   w_rsp_data;
    logic                w_core_rvalid;
    logic                w_dbg_rvalid;

    arb_prio_sel #(
        .STARVE_LIM (STARVE_LIM)
    ) u_prio_sel (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_core_req (i_core_req),
        .i_dbg_req  (i_dbg_req),
        .i_core_gnt (w_core_gnt),
        .i_dbg_gnt  (w_dbg_gnt),
        .o_sel_c    (w_sel)
    );

    // Memory request fields follow the selected requester.
    always_comb begin
        w_sel_we    = i_core_we;
        o_mem_we    = i_core_we;
        o_mem_addr  = i_core_addr;
        o_mem_wdata = i_core_wdata;
        o_mem_bmask = i_core_bmask;
        if (w_sel == OWN_DBG) begin
            w_sel_we    = i_dbg_we;
            o_mem_we    = i_dbg_we;
            o_mem_addr  = i_dbg_addr;
            o_mem_wdata = i_dbg_wdata;
            o_mem_bmask = i_dbg_bmask;
        end
    end

    // Next-state, grants and response generation.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_any_req   = 1'b0;
        w_core_gnt  = 1'b0;
        w_dbg_gnt   = 1'b0;
        w_rsp_valid = 1'b0;
        w_tmo_fire  = 1'b0;
        w_rsp_data  = '0;
        case (r_state)
            IDLE: begin
                w_any_req = i_core_req | i_dbg_req;
                if (w_any_req && i_mem_ready) begin
                    if (w_sel == OWN_DBG) begin
                        w_dbg_gnt = 1'b1;
                    end else begin
                        w_core_gnt = 1'b1;
                    end
                    // Stores complete on handshake; loads wait for data.
                    if (!w_sel_we) begin
                        w_owner_nxt = w_sel;
                        w_state_nxt = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (i_mem_rvalid) begin
                    w_rsp_valid = 1'b1;
                    w_rsp_data  = i_mem_rdata;
                    w_state_nxt = IDLE;
                end else if (r_tmo_cnt == TMO_W'(TIMEOUT)) begin
                    // Synthetic zero response so the owner never hangs.
                    w_rsp_valid = 1'b1;
                    w_tmo_fire  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FSM state and owner registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_owner <= OWN_CORE;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // Timeout counter runs only while a read stays outstanding; error flags are sticky.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_tmo_cnt <= '0;
            r_err     <= '0;
        end else begin
            if ((r_state == RD_WAIT) && (w_state_nxt == RD_WAIT)) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end else begin
                r_tmo_cnt <= '0;
            end
            if (w_tmo_fire) begin
                r_err[ERR_TMO] <= 1'b1;
            end
            if ((r_state == IDLE) && i_mem_rvalid) begin
                r_err[ERR_SPUR] <= 1'b1;
            end
        end
    end

    assign w_core_rvalid = w_rsp_valid & (r_owner == OWN_CORE);
    assign w_dbg_rvalid  = w_rsp_valid & (r_owner == OWN_DBG);

    assign o_mem_req     = w_any_req;
    assign o_core_gnt    = w_core_gnt;
    assign o_dbg_gnt     = w_dbg_gnt;
    assign o_core_rvalid = w_core_rvalid;
    assign o_dbg_rvalid  = w_dbg_rvalid;
    assign o_core_rdata  = w_core_rvalid ? w_rsp_data : '0;
    assign o_dbg_rdata   = w_dbg_rvalid ? w_rsp_data : '0;
    // Core holds until its store is accepted or its load data returns.
    assign o_core_stall  = i_core_req & ~(w_core_gnt & i_core_we) & ~w_core_rvalid;
    assign o_err         = r_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus queues expected grant/response events,
// a negedge monitor pops and compares them; side-band outputs are checked inline.
module tb_dmem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          core_req, core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic [BW-1:0] core_bmask;
    logic          core_gnt, core_rvalid, core_stall;
    logic [DW-1:0] core_rdata;
    logic          dbg_req, dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic [BW-1:0] dbg_bmask;
    logic          dbg_gnt, dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_bmask;
    logic          mem_ready, mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    err;

    dmem_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_LIM (4),
        .TIMEOUT    (255)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_core_req    (core_req),
        .i_core_we     (core_we),
        .i_core_addr   (core_addr),
        .i_core_wdata  (core_wdata),
        .i_core_bmask  (core_bmask),
        .o_core_gnt    (core_gnt),
        .o_core_rvalid (core_rvalid),
        .o_core_rdata  (core_rdata),
        .o_core_stall  (core_stall),
        .i_dbg_req     (dbg_req),
        .i_dbg_we      (dbg_we),
        .i_dbg_addr    (dbg_addr),
        .i_dbg_wdata   (dbg_wdata),
        .i_dbg_bmask   (dbg_bmask),
        .o_dbg_gnt     (dbg_gnt),
        .o_dbg_rvalid  (dbg_rvalid),
        .o_dbg_rdata   (dbg_rdata),
        .o_mem_req     (mem_req),
        .o_mem_we      (mem_we),
        .o_mem_addr    (mem_addr),
        .o_mem_wdata   (mem_wdata),
        .o_mem_bmask   (mem_bmask),
        .i_mem_ready   (mem_ready),
        .i_mem_rvalid  (mem_rvalid),
        .i_mem_rdata   (mem_rdata),
        .o_err         (err)
    );

    always #5 clk = ~clk;

    typedef enum logic [1:0] {EV_CGNT, EV_DGNT, EV_CRV, EV_DRV} ev_kind_e;
    typedef struct {
        string         nm;
        ev_kind_e      kind;
        int            cyc;
        logic [DW-1:0] data;
    } ev_t;

    ev_t sb_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic push(input string nm, input ev_kind_e k, input logic [DW-1:0] d);
        ev_t e;
        e.nm   = nm;
        e.kind = k;
        e.cyc  = cyc;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic mon_event(input ev_kind_e k, input logic [DW-1:0] d);
        ev_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected cyc=%0d actual kind=%0d data=%h required no event", cyc, k, d);
        end else begin
            e = sb_q.pop_front();
            if (e.kind !== k || e.cyc != cyc || e.data !== d) begin
                failures++;
                $display("FAIL %s actual kind=%0d cyc=%0d data=%h required kind=%0d cyc=%0d data=%h",
                         e.nm, k, cyc, d, e.kind, e.cyc, e.data);
            end
        end
    endtask

    // Monitor: every grant/response the DUT presents must match the next queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (core_gnt)    mon_event(EV_CGNT, '0);
            if (dbg_gnt)     mon_event(EV_DGNT, '0);
            if (core_rvalid) mon_event(EV_CRV, core_rdata);
            if (dbg_rvalid)  mon_event(EV_DRV, dbg_rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic clr();
        core_req   = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0; core_bmask = '0;
        dbg_req    = 1'b0; dbg_we  = 1'b0; dbg_addr  = '0; dbg_wdata  = '0; dbg_bmask  = '0;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    initial begin
        clr();
        rst_n = 1'b0;
        repeat (3) tick();
        samp();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_stall",   32'(core_stall), 32'd0);
        chk("rst_err",     32'(err), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // T1: core load, data one cycle after grant
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h100; core_bmask = 4'hF;
        push("t1_gnt", EV_CGNT, '0);
        samp();
        chk("t1_stall_c0", 32'(core_stall), 32'd1);
        chk("t1_mem_addr", mem_addr, 32'h100);
        chk("t1_mem_we",   32'(mem_we), 32'd0);
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE0001;
        push("t1_rvalid", EV_CRV, 32'hCAFE0001);
        samp();
        chk("t1_stall_c1",   32'(core_stall), 32'd0);
        chk("t1_mem_req_rw", 32'(mem_req), 32'd0);
        tick();
        clr();

        // T2: core store, single-cycle, no stall
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h200; core_wdata = 32'h55; core_bmask = 4'b0001;
        push("t2_gnt", EV_CGNT, '0);
        samp();
        chk("t2_stall",     32'(core_stall), 32'd0);
        chk("t2_mem_we",    32'(mem_we), 32'd1);
        chk("t2_mem_bmask", 32'(mem_bmask), 32'd1);
        chk("t2_mem_wdata", mem_wdata, 32'h55);
        chk("t2_mem_addr",  mem_addr, 32'h200);
        tick();
        clr();

        // T3: both store every cycle -> 4 core grants then 1 debug grant, repeating
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h400; core_wdata = 32'h1; core_bmask = 4'hF;
        dbg_req  = 1'b1; dbg_we  = 1'b1; dbg_addr  = 32'h800; dbg_wdata  = 32'h2; dbg_bmask  = 4'hF;
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) push("t3_dgnt", EV_DGNT, '0);
            else            push("t3_cgnt", EV_CGNT, '0);
            samp();
            if (i % 5 == 4) begin
                chk("t3_mem_addr_dbg", mem_addr, 32'h800);
                chk("t3_stall_dbg",    32'(core_stall), 32'd1);
            end
            tick();
        end
        clr();
        tick();

        // T3b: no-ready hold, debug load, core request waiting behind a debug response
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h500; mem_ready = 1'b0;
        samp();
        chk("t3b_mem_req_noready", 32'(mem_req), 32'd1);
        chk("t3b_stall_noready",   32'(core_stall), 32'd1);
        tick();
        core_req = 1'b0; mem_ready = 1'b1;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h300;
        push("t3b_dgnt", EV_DGNT, '0);
        samp();
        chk("t3b_mem_addr", mem_addr, 32'h300);
        tick();
        dbg_req = 1'b0;
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h600;
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        push("t3b_drv", EV_DRV, 32'h12345678);
        samp();
        chk("t3b_stall_rdwait", 32'(core_stall), 32'd1);
        tick();
        mem_rvalid = 1'b0;
        push("t3b_cgnt", EV_CGNT, '0);
        samp();
        tick();
        core_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D;
        push("t3b_crv", EV_CRV, 32'h0BADF00D);
        samp();
        tick();
        clr();

        // T4: load with no response -> synthetic zero after 255 wait cycles, timeout flag
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h700;
        push("t4_gnt", EV_CGNT, '0);
        samp();
        tick();
        core_req = 1'b0; mem_rdata = 32'hFFFFFFFF;
        repeat (255) tick();
        push("t4_tmo_rv", EV_CRV, '0);
        samp();
        chk("t4_err_pre", 32'(err), 32'd0);
        tick();
        samp();
        chk("t4_err", 32'(err), 32'd1);
        tick();
        clr();

        // T5: spurious rvalid in IDLE
        mem_rvalid = 1'b1; mem_rdata = 32'h1111;
        samp();
        chk("t5_mem_req", 32'(mem_req), 32'd0);
        tick();
        mem_rvalid = 1'b0;
        samp();
        chk("t5_err", 32'(err), 32'd3);
        repeat (3) tick();
        samp();
        chk("t5_err_sticky", 32'(err), 32'd3);
        tick();

        // T6: reset during RD_WAIT, late rvalid is spurious
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h900;
        push("t6_gnt", EV_CGNT, '0);
        samp();
        tick();
        core_req = 1'b0; rst_n = 1'b0;
        samp();
        tick();
        rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD;
        samp();
        chk("t6_err_after_rst", 32'(err), 32'd0);
        tick();
        mem_rvalid = 1'b0;
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'hA00;
        push("t6_idle_gnt", EV_CGNT, '0);
        samp();
        chk("t6_err_spur", 32'(err), 32'd2);
        tick();
        clr();
        samp();
        tick();
        samp();

        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_pending actual=%0d outstanding required=0 first=%s", sb_q.size(), sb_q[0].nm);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
